// File: rtl/prbs_ber_checker.sv
// prbs_ber_checker: self-synchronising PRBS checker with windowed BER and sync-loss detection.
// Outputs registered one cycle after the causing bit; no backpressure, advances only when bit_valid.
module prbs_ber_checker #(
  parameter int                LFSR_W     = 7,
  parameter logic [LFSR_W-1:0] TAPS       = 7'h60,
  parameter int                VERIFY_LEN = 32,
  parameter int                WINDOW     = 1024,
  parameter int                LOSS_BLK   = 64,
  parameter int                LOSS_THR   = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        bit_valid,
  input  logic        bit_i,
  input  logic        clear,
  output logic        locked,
  output logic        sync_loss,
  output logic        window_done,
  output logic [31:0] window_errs,
  output logic [31:0] err_total,
  output logic [31:0] bit_total
);
  localparam int SEED_CW = $clog2(LFSR_W + 1);
  localparam int VER_CW  = $clog2(VERIFY_LEN + 1);
  localparam int WIN_CW  = $clog2(WINDOW + 1);
  localparam int BLK_CW  = $clog2(LOSS_BLK + 1);

  typedef enum logic [1:0] {ST_SEED, ST_VERIFY, ST_LOCKED} state_t;
  state_t state, state_nxt;

  logic [LFSR_W-1:0]  lfsr, lfsr_nxt;
  logic [SEED_CW-1:0] seed_cnt;
  logic [VER_CW-1:0]  ver_cnt;
  logic [WIN_CW-1:0]  win_bits;
  logic [31:0]        win_errs;
  logic [BLK_CW-1:0]  blk_bits, blk_errs, blk_errs_sum;
  logic               fb, err, seed_last;
  logic               win_hit, blk_hit, loss_hit;

  // Seeding shifts in the received bit; afterwards the LFSR free-runs on its own feedback.
  assign fb           = ^(lfsr & TAPS);
  assign err          = bit_i ^ fb;
  assign lfsr_nxt     = {lfsr[LFSR_W-2:0], (state == ST_SEED) ? bit_i : fb};
  assign blk_errs_sum = blk_errs + BLK_CW'(err);
  assign seed_last    = (seed_cnt == SEED_CW'(LFSR_W - 1));

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= ST_SEED;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    win_hit   = 1'b0;
    blk_hit   = 1'b0;
    loss_hit  = 1'b0;
    if (bit_valid) begin
      case (state)
        ST_SEED: begin
          // An all-zero seed would lock the LFSR at zero forever.
          if (seed_last && (lfsr_nxt != '0)) state_nxt = ST_VERIFY;
        end
        ST_VERIFY: begin
          if (err)                                         state_nxt = ST_SEED;
          else if (ver_cnt == VER_CW'(VERIFY_LEN - 1))     state_nxt = ST_LOCKED;
        end
        ST_LOCKED: begin
          blk_hit = (blk_bits == BLK_CW'(LOSS_BLK - 1));
          if (blk_errs_sum >= BLK_CW'(LOSS_THR)) begin
            state_nxt = ST_SEED;
            loss_hit  = 1'b1;
          end else begin
            win_hit = (win_bits == WIN_CW'(WINDOW - 1));
          end
        end
        default: state_nxt = ST_SEED;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      lfsr        <= '0;
      seed_cnt    <= '0;
      ver_cnt     <= '0;
      win_bits    <= '0;
      win_errs    <= '0;
      blk_bits    <= '0;
      blk_errs    <= '0;
      locked      <= 1'b0;
      sync_loss   <= 1'b0;
      window_done <= 1'b0;
      window_errs <= '0;
      err_total   <= '0;
      bit_total   <= '0;
    end else begin
      locked      <= (state_nxt == ST_LOCKED);
      sync_loss   <= loss_hit;
      window_done <= win_hit;
      if (bit_valid) begin
        lfsr <= lfsr_nxt;
        case (state)
          ST_SEED: begin
            seed_cnt <= seed_last ? '0 : seed_cnt + SEED_CW'(1);
            ver_cnt  <= '0;
          end
          ST_VERIFY: begin
            ver_cnt  <= ver_cnt + VER_CW'(1);
            win_bits <= '0;
            win_errs <= '0;
            blk_bits <= '0;
            blk_errs <= '0;
          end
          ST_LOCKED: begin
            win_bits <= win_hit ? '0 : win_bits + WIN_CW'(1);
            win_errs <= win_hit ? '0 : win_errs + 32'(err);
            if (win_hit) window_errs <= win_errs + 32'(err);
            blk_bits <= blk_hit ? '0 : blk_bits + BLK_CW'(1);
            blk_errs <= blk_hit ? '0 : blk_errs_sum;
          end
          default: ;
        endcase
      end
      // A clear coinciding with a counted bit leaves the totals at zero.
      if (clear) begin
        err_total <= '0;
        bit_total <= '0;
      end else if (bit_valid && (state == ST_LOCKED)) begin
        if (bit_total != '1)         bit_total <= bit_total + 32'd1;
        if (err && (err_total != '1)) err_total <= err_total + 32'd1;
      end
    end
  end

endmodule
